conv_output_serializer: RTL and testbench
=========================================

# conv_output_serializer

- Sits at the output end of the convolution layer, between the MAC array result bus and the output DMA.
- Accepts one POF-wide vector of signed accumulators per `in_valid` cycle. The conv layer cannot apply backpressure, so there is no `in_ready`.
- Requantizes each lane to DATA_WIDTH, buffers the vectors in a FIFO, and emits one channel per beat on a valid/ready stream.
- Marks the last beat of each frame and flags dropped data.

## Interface
Parameters:
- DATA_WIDTH, 16, output sample width (signed)
- ACC_WIDTH, 33, accumulator width per lane (signed)
- POF, 4, lanes (output filters) per input vector; must be ≥ 2
- FRAC_SHIFT, 8, arithmetic right shift applied before saturation
- FIFO_DEPTH, 16, vector entries; power of two
- FRAME_OUTPUTS, 408318, input vectors per frame

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  accumulator vector valid this cycle
- in_data  in  POF*ACC_WIDTH  lane i at [i*ACC_WIDTH +: ACC_WIDTH]
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts beat
- m_data  out  DATA_WIDTH  quantized sample
- m_chan  out  $clog2(POF)  lane index of m_data
- m_last  out  1  last beat of frame
- frame_done  out  1  one-cycle pulse when the m_last beat handshakes
- overflow  out  1  sticky; set when a vector is dropped because the FIFO is full
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries

## Operation
- **Quantize stage (registered):** per lane, q = acc >>> FRAC_SHIFT (arithmetic, floor).
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Stage output: POF quantized lanes, a valid bit and a last tag.
- **Frame counter:** counts every `in_valid` vector, including dropped ones.
  - last tag = (count == FRAME_OUTPUTS-1).
  - On that vector the counter wraps to 0.
- **FIFO push:** stage valid pushes {lanes, last} when not full.
  - A push is also accepted when the FIFO is full and a pop occurs on the same edge; level stays unchanged.
  - Otherwise the vector is discarded and overflow is set; it stays set until rst.
  - A dropped last-tagged vector produces no m_last for that frame.
- **Serializer:**
  - Head entry and lane counter `lane` (0..POF-1).
  - m_valid = FIFO not empty.
  - m_data = head lane[`lane`]; m_chan = `lane`.
  - m_last = head.last && `lane`==POF-1.
  - On a handshake (m_valid && m_ready): `lane` increments; at POF-1 it wraps to 0 and the head entry pops.
- **States:**
  - EMPTY (m_valid=0)
  - STREAM (head present, `lane` advancing)
  - EMPTY is re-entered when the final lane of the final entry handshakes and no push is pending.
- m_data, m_chan and m_last are held stable while m_valid && !m_ready.
- m_valid is never retracted without a handshake.
- frame_done: registered one-cycle pulse, the cycle after the m_last handshake.

## Timing
- **Reset values:** m_valid=0, m_data=0, m_chan=0, m_last=0, frame_done=0, overflow=0, fifo_level=0. FIFO is emptied; frame and lane counters are zeroed.
- **Reset mid-frame:** all buffered data is discarded, and the next in_valid is counted as vector 0 of a new frame.
- **Latency:**
  - in_valid at edge t is registered by the quantize stage at t+1.
  - The FIFO write occurs at t+2; m_valid rises after t+2 if the FIFO was empty.
- **Throughput:** one beat per cycle with m_ready held high. One vector drains every POF cycles.
  - Sustained in_valid faster than 1/POF overflows after about FIFO_DEPTH vectors.
- fifo_level updates on the edge of a push or pop; a simultaneous push and pop leaves it unchanged.
- An m_ready toggle with m_valid=0 has no effect.

## Configuration
- Macro: `CONV_OUT_RELU_EN`.
  - **Defined:** negative accumulators are forced to 0 before the shift, so lanes lie in [0, 2^(DATA_WIDTH-1)-1].
  - **Undefined:** signed floor and saturation as above.

## Test plan
Tests use defaults, FRAC_SHIFT=8, DATA_WIDTH=16.
- **Quantize and order.** Stimulus: one vector, lanes {0x1234, 0x100, 0, 0x7FFF00}, m_ready=1. Response:
  - beats m_data=0x0012, 0x0001, 0x0000, 0x7FFF;
  - m_chan 0..3;
  - first beat 2 cycles after in_valid.
- **Saturation and negatives.** Stimulus: lanes {2^24, -512, -2^30, -1}. Response:
  - without the macro: 0x7FFF, 0xFFFE, 0x8000, 0xFFFF;
  - with `CONV_OUT_RELU_EN`: 0x7FFF, 0, 0, 0.
- **Backpressure.** Stimulus: m_ready=0 for 10 cycles, then 1. Response: first beat held unchanged for all 10 cycles; no beat is lost or duplicated.
- **Overflow.** Stimulus: m_ready=0, 17 consecutive vectors. Response:
  - fifo_level=16; overflow=1;
  - after draining, exactly 64 beats come out, from vectors 0..15.
- **Frame boundary.** Stimulus: FRAME_OUTPUTS=3, 6 vectors. Response:
  - m_last on beats 12 and 24;
  - frame_done pulses twice.
- **Reset mid-stream.** Stimulus: rst during beat 2 of a vector. Response:
  - all outputs 0 the next cycle;
  - the next vector is counted as frame position 0.

Source files
------------

// File: rtl/conv_output_serializer.sv
// conv_output_serializer: requantizes POF-lane accumulator vectors, buffers them in a FIFO and
// streams one channel per beat. Define CONV_OUT_RELU_EN to clamp negative accumulators to 0.
module conv_output_serializer #(
  parameter int DATA_WIDTH    = 16,
  parameter int ACC_WIDTH     = 33,
  parameter int POF           = 4,
  parameter int FRAC_SHIFT    = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int FRAME_OUTPUTS = 408318
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [POF*ACC_WIDTH-1:0]        in_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic [$clog2(POF)-1:0]          m_chan,
  output logic                            m_last,
  output logic                            frame_done,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int LW  = $clog2(POF);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LVW = PW + 1;
  localparam int FCW = (FRAME_OUTPUTS > 1) ? $clog2(FRAME_OUTPUTS) : 1;
  localparam int EW  = POF * DATA_WIDTH + 1;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {S_EMPTY, S_STREAM} state_t;

  logic [POF*DATA_WIDTH-1:0]   q_lanes_d, q_lanes_q;
  logic                        q_valid_d, q_valid_q;
  logic                        q_last_d, q_last_q;
  logic [FCW-1:0]              frame_cnt_d, frame_cnt_q;
  logic signed [ACC_WIDTH-1:0] acc_s, shr_s;

  logic [EW-1:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [LVW-1:0] level_d, level_q;
  logic [LW-1:0]  lane_d, lane_q;
  logic           overflow_d, overflow_q;
  logic           frame_done_d, frame_done_q;
  state_t         state_d, state_q;
  logic           hs, pop, push, full;
  logic [EW-1:0]  head;

  // Quantize: optional ReLU, arithmetic shift (floor), then saturate to DATA_WIDTH.
  always_comb begin
    q_lanes_d = '0;
    acc_s     = '0;
    shr_s     = '0;
    for (int unsigned i = 0; i < POF; i++) begin
      acc_s = $signed(in_data[i*ACC_WIDTH +: ACC_WIDTH]);
`ifdef CONV_OUT_RELU_EN
      if (acc_s[ACC_WIDTH-1]) acc_s = '0;
`endif
      shr_s = acc_s >>> FRAC_SHIFT;
      if (shr_s > SAT_MAX)
        q_lanes_d[i*DATA_WIDTH +: DATA_WIDTH] = SAT_MAX[DATA_WIDTH-1:0];
      else if (shr_s < SAT_MIN)
        q_lanes_d[i*DATA_WIDTH +: DATA_WIDTH] = SAT_MIN[DATA_WIDTH-1:0];
      else
        q_lanes_d[i*DATA_WIDTH +: DATA_WIDTH] = shr_s[DATA_WIDTH-1:0];
    end
  end

  // Frame position advances on every input vector, dropped or not.
  always_comb begin
    q_valid_d   = in_valid;
    q_last_d    = 1'b0;
    frame_cnt_d = frame_cnt_q;
    if (in_valid) begin
      q_last_d    = (frame_cnt_q == FCW'(FRAME_OUTPUTS - 1));
      frame_cnt_d = q_last_d ? '0 : frame_cnt_q + FCW'(1);
    end
  end

  assign full = (level_q == LVW'(FIFO_DEPTH));
  assign head = mem_q[rd_ptr_q];
  assign hs   = m_valid && m_ready;
  assign pop  = hs && (lane_q == LW'(POF - 1));
  assign push = q_valid_q && (!full || pop);

  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d      = level_q + LVW'(push) - LVW'(pop);
    lane_d       = lane_q;
    if (hs) lane_d = (lane_q == LW'(POF - 1)) ? '0 : lane_q + LW'(1);
    overflow_d   = overflow_q | (q_valid_q && !push);
    frame_done_d = hs && m_last;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY:  if (push) state_d = S_STREAM;
      S_STREAM: if (pop && !push && level_q == LVW'(1)) state_d = S_EMPTY;
      default:  state_d = S_EMPTY;
    endcase
  end

  // Outputs are forced to zero while empty so unreset FIFO storage never shows.
  always_comb begin
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = '0;
    m_last  = 1'b0;
    if (state_q == S_STREAM) begin
      m_valid = 1'b1;
      m_data  = head[lane_q*DATA_WIDTH +: DATA_WIDTH];
      m_chan  = lane_q;
      m_last  = head[EW-1] && (lane_q == LW'(POF - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_lanes_q    <= '0;
      q_valid_q    <= 1'b0;
      q_last_q     <= 1'b0;
      frame_cnt_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      lane_q       <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      q_lanes_q    <= q_lanes_d;
      q_valid_q    <= q_valid_d;
      q_last_q     <= q_last_d;
      frame_cnt_q  <= frame_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      lane_q       <= lane_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {q_last_q, q_lanes_q};
  end

  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_output_serializer.sv
// Self-checking bench for conv_output_serializer: queue-based reference model compared every
// cycle, plus directed vectors with hand-computed beats.
module tb_conv_output_serializer;

  localparam int DW = 16, AW = 33, P = 4, FS = 8, DEPTH = 16, FRAME = 3;
  localparam int LW = $clog2(P), LVW = $clog2(DEPTH) + 1;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, m_ready = 1'b0;
  logic [P*AW-1:0] in_data = '0;
  logic            m_valid, m_last, frame_done, overflow;
  logic [DW-1:0]   m_data;
  logic [LW-1:0]   m_chan;
  logic [LVW-1:0]  fifo_level;

  always #5 clk = ~clk;

  conv_output_serializer #(
    .DATA_WIDTH(DW), .ACC_WIDTH(AW), .POF(P), .FRAC_SHIFT(FS),
    .FIFO_DEPTH(DEPTH), .FRAME_OUTPUTS(FRAME)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_chan(m_chan),
    .m_last(m_last), .frame_done(frame_done), .overflow(overflow),
    .fifo_level(fifo_level)
  );

  typedef struct packed { logic last; logic [P*DW-1:0] lanes; } ent_t;
  typedef struct packed { logic [DW-1:0] data; logic [LW-1:0] chan; logic last; } beat_t;

  ent_t  mq[$];
  ent_t  st_ent;
  bit    st_valid, ovf, fd, chk_en, m_hs, m_pop, m_full;
  int    fpos, lane, fd_cnt;
  beat_t beats[$];
  int    n_tests, n_fail;
  logic [DW-1:0] e_data;
  bit    found;

  function automatic logic [DW-1:0] quant(input logic [AW-1:0] raw);
    longint v, q, lim, div;
    v   = longint'($signed(raw));
`ifdef CONV_OUT_RELU_EN
    if (v < 0) v = 0;
`endif
    div = longint'(1) << FS;
    if (v >= 0) q = v / div;
    else        q = -((-v + div - 1) / div);
    lim = longint'(1) << (DW - 1);
    if (q > lim - 1) q = lim - 1;
    else if (q < -lim) q = -lim;
    return q[DW-1:0];
  endfunction

  function automatic logic [AW-1:0] rand_acc();
    logic [AW-1:0] r;
    longint v;
    case ($urandom_range(0, 3))
      0: r = AW'({$urandom, $urandom});
      1: begin v = longint'($urandom_range(0, 131072)) - 65536; r = AW'(v); end
      2: begin
        v = (longint'(1) << 23) + longint'($urandom_range(0, 2048)) - 1024;
        if ($urandom_range(0, 1) == 1) v = -v;
        r = AW'(v);
      end
      default: r = ($urandom_range(0, 1) == 1) ? {1'b0, {(AW-1){1'b1}}} : {1'b1, {(AW-1){1'b0}}};
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input logic [AW-1:0] a0, a1, a2, a3);
    in_data = {a3, a2, a1, a0};
  endtask

  task automatic rand_vec();
    for (int i = 0; i < P; i++) in_data[i*AW +: AW] = rand_acc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic int count_lasts();
    int n = 0;
    foreach (beats[i]) if (beats[i].last) n++;
    return n;
  endfunction

  // Reference model: stage register, vector queue and lane pointer updated at each edge.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      mq.delete();
      st_valid = 0; fpos = 0; lane = 0; ovf = 0; fd = 0;
      chk_en = 1;
    end else begin
      m_hs   = (mq.size() > 0) && m_ready;
      m_pop  = m_hs && (lane == P - 1);
      m_full = (mq.size() == DEPTH);
      fd     = m_pop && mq[0].last;
      if (m_pop) void'(mq.pop_front());
      if (m_hs) lane = (lane + 1) % P;
      if (st_valid) begin
        if (!m_full || m_pop) mq.push_back(st_ent);
        else ovf = 1;
      end
      st_valid = in_valid;
      if (in_valid) begin
        for (int i = 0; i < P; i++) st_ent.lanes[i*DW +: DW] = quant(in_data[i*AW +: AW]);
        st_ent.last = (fpos == FRAME - 1);
        fpos = (fpos + 1) % FRAME;
      end
    end
  end

  // Compare process plus beat recorder, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      if (mq.size() > 0) begin
        e_data = mq[0].lanes[lane*DW +: DW];
        check("m_valid", m_valid, 1);
        check("m_data", m_data, e_data);
        check("m_chan", m_chan, lane);
        check("m_last", m_last, mq[0].last && (lane == P - 1));
      end else begin
        check("m_valid", m_valid, 0);
        check("m_data_idle", m_data, 0);
        check("m_chan_idle", m_chan, 0);
        check("m_last_idle", m_last, 0);
      end
      check("fifo_level", fifo_level, mq.size());
      check("overflow", overflow, ovf);
      check("frame_done", frame_done, fd);
    end
    if (m_valid === 1'b1 && m_ready === 1'b1) beats.push_back('{m_data, m_chan, m_last});
    if (frame_done === 1'b1) fd_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_tests = 0; n_fail = 0; fd_cnt = 0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_m_valid", m_valid, 0);
    check("reset_m_data", m_data, 0);
    check("reset_level", fifo_level, 0);
    check("reset_overflow", overflow, 0);

    // Quantize and order, with first-beat latency.
    m_ready = 1'b1;
    beats.delete();
    tick();
    in_valid = 1'b1;
    set_vec(33'h1234, 33'h100, 33'h0, 33'h7FFF00);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_idle", m_valid, 0);
    @(negedge clk);
    check("lat_first", m_valid, 1);
    check("q_first_data", m_data, 16'h0012);
    repeat (6) tick();
    check("q_count", beats.size(), 4);
    if (beats.size() == 4) begin
      check("q_b0", beats[0].data, 16'h0012);
      check("q_b1", beats[1].data, 16'h0001);
      check("q_b2", beats[2].data, 16'h0000);
      check("q_b3", beats[3].data, 16'h7FFF);
      for (int i = 0; i < 4; i++) check("q_chan", beats[i].chan, i);
    end

    // Saturation and negatives.
    beats.delete();
    in_valid = 1'b1;
    set_vec(33'(1 << 24), 33'(-512), 33'(-(1 << 30)), 33'(-1));
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    check("sat_count", beats.size(), 4);
    if (beats.size() == 4) begin
      check("sat_b0", beats[0].data, 16'h7FFF);
`ifdef CONV_OUT_RELU_EN
      check("sat_b1", beats[1].data, 16'h0000);
      check("sat_b2", beats[2].data, 16'h0000);
      check("sat_b3", beats[3].data, 16'h0000);
`else
      check("sat_b1", beats[1].data, 16'hFFFE);
      check("sat_b2", beats[2].data, 16'h8000);
      check("sat_b3", beats[3].data, 16'hFFFF);
`endif
    end

    // Backpressure: third vector since reset, so it carries the frame-last tag.
    m_ready = 1'b0;
    beats.delete();
    in_valid = 1'b1;
    set_vec(33'h500, 33'h600, 33'h700, 33'h800);
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", m_valid, 1);
      check("bp_data", m_data, 16'h0005);
      check("bp_chan", m_chan, 0);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    repeat (8) tick();
    check("bp_count", beats.size(), 4);
    if (beats.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("bp_beat", beats[i].data, 5 + i);
        check("bp_beat_chan", beats[i].chan, i);
      end
      check("bp_last", beats[3].last, 1);
    end

    // Overflow: 17 vectors into a 16-entry FIFO with no drain.
    do_reset();
    m_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rand_vec();
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("ovf_level", fifo_level, 16);
    check("ovf_flag", overflow, 1);
    beats.delete();
    @(posedge clk); #1;
    m_ready = 1'b1;
    repeat (80) tick();
    check("ovf_beats", beats.size(), 64);
    check("ovf_sticky", overflow, 1);
    check("ovf_drained", fifo_level, 0);

    // Frame boundary with FRAME_OUTPUTS=3.
    do_reset();
    m_ready = 1'b1;
    beats.delete();
    fd_cnt = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_vec();
      tick();
    end
    in_valid = 1'b0;
    repeat (40) tick();
    check("frm_beats", beats.size(), 24);
    if (beats.size() == 24) begin
      check("frm_last12", beats[11].last, 1);
      check("frm_last24", beats[23].last, 1);
    end
    check("frm_nlast", count_lasts(), 2);
    check("frm_done_cnt", fd_cnt, 2);

    // Reset mid-stream restarts the frame count.
    do_reset();
    m_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_vec();
      tick();
    end
    in_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (m_valid === 1'b1 && m_chan == 2) found = 1;
    end
    check("rm_reach_beat2", found, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rm_valid", m_valid, 0);
    check("rm_data", m_data, 0);
    check("rm_chan", m_chan, 0);
    check("rm_last", m_last, 0);
    check("rm_level", fifo_level, 0);
    check("rm_frame_done", frame_done, 0);
    beats.delete();
    tick();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_vec();
      tick();
    end
    in_valid = 1'b0;
    repeat (30) tick();
    check("rm_beats", beats.size(), 12);
    if (beats.size() == 12) check("rm_last12", beats[11].last, 1);
    check("rm_nlast", count_lasts(), 1);

    // Randomized traffic with varying input rate, backpressure and rare resets.
    do_reset();
    for (int seg = 0; seg < 8; seg++) begin
      int in_rate, rdy_rate;
      in_rate  = (seg % 4 == 0) ? 10 : (seg % 4 == 1) ? 25 : (seg % 4 == 2) ? 60 : 100;
      rdy_rate = (seg % 3 == 0) ? 100 : (seg % 3 == 1) ? 70 : 30;
      for (int c = 0; c < 200; c++) begin
        in_valid = ($urandom_range(0, 99) < in_rate);
        m_ready  = ($urandom_range(0, 99) < rdy_rate);
        rst      = ($urandom_range(0, 499) == 0);
        rand_vec();
        tick();
      end
    end
    rst = 1'b0;
    in_valid = 1'b0;
    m_ready = 1'b1;
    repeat (80) tick();
    check("final_level", fifo_level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
